// File: rtl/demux4_32_reg_pkg.sv
// demux4_pkg: shared constants and types for the 1:4 registered demux.
package demux4_pkg;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/demux4_32_reg_slot.sv
// demux_slot: one-entry holding slot with a valid/ready handshake to its consumer.
module demux_slot
    import demux4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic             can_load
);
    slot_state_t state, state_nx;

    // State register; synchronous active-low reset drops any held word.
    always_ff @(posedge clk) begin
        if (!rst) state <= SLOT_EMPTY;
        else      state <= state_nx;
    end

    // Data register; only an accept changes the held word.
    always_ff @(posedge clk) begin
        if (!rst)      y <= '0;
        else if (load) y <= data;
    end

    // Load wins over drain, so a simultaneous drain and accept stays FULL.
    always_comb begin
        state_nx = state;
        if (load)                                  state_nx = SLOT_FULL;
        else if (state == SLOT_FULL && out_ready) state_nx = SLOT_EMPTY;
    end

    assign valid    = (state == SLOT_FULL);
    assign can_load = ~valid | out_ready;
endmodule

// File: rtl/demux4_32_reg.sv
// demux4_32_reg: 1:4 registered demux with per-channel holding slots.
// Optional DEMUX4_STATS_EN adds stat_cnt with four wrapping 8-bit handshake counters.
module demux4_32_reg
    import demux4_pkg::NCH;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready
`ifdef DEMUX4_STATS_EN
    ,
    output logic [31:0]      stat_cnt
`endif
);
    logic [NCH-1:0]   load, can_load;
    logic [WIDTH-1:0] y_arr [NCH];
    logic             accept;

    assign in_ready = rst & can_load[s];
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        assign load[i] = accept & (s == SEL_W'(i));
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .data     (d),
            .out_ready(out_ready[i]),
            .y        (y_arr[i]),
            .valid    (out_valid[i]),
            .can_load (can_load[i])
        );
    end

    assign y0 = y_arr[0];
    assign y1 = y_arr[1];
    assign y2 = y_arr[2];
    assign y3 = y_arr[3];

`ifdef DEMUX4_STATS_EN
    import demux4_pkg::CNT_W;
    logic [CNT_W-1:0] cnt [NCH];

    // Count output handshakes per channel; natural 8-bit wrap.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (!rst)                              cnt[k] <= '0;
            else if (out_valid[k] & out_ready[k]) cnt[k] <= cnt[k] + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_stat
        assign stat_cnt[CNT_W*i +: CNT_W] = cnt[i];
    end
`endif
endmodule

// File: tb/tb_demux4_32_reg.sv
// tb_demux4_32_reg: directed self-checking bench for demux4_32_reg (stats checks when DEMUX4_STATS_EN is defined).
module tb_demux4_32_reg;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [1:0]  s = 0;
    logic [31:0] d = 0;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 0;
`ifdef DEMUX4_STATS_EN
    logic [31:0] stat_cnt;
`endif
    int pass = 0;
    int total = 0;

    demux4_32_reg dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s        (s),
        .d        (d),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef DEMUX4_STATS_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Source rule: a blocked request must keep s and d stable until accepted.
    logic        held = 0;
    logic [1:0]  held_s;
    logic [31:0] held_d;
    always @(posedge clk) begin
        if (held && in_valid) check("src_stable", {s, d[29:0]}, {held_s, held_d[29:0]});
        held   <= rst && in_valid && !in_ready;
        held_s <= s;
        held_d <= d;
    end

    initial begin
        // Reset held for two cycles with a request pending
        in_valid = 1; s = 0; d = 32'h11;
        step(); step();
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_y0", y0, 0);
        check("rst_y1", y1, 0);
        check("rst_y2", y2, 0);
        check("rst_y3", y3, 0);
        check("rst_in_ready", in_ready, 0);
`ifdef DEMUX4_STATS_EN
        check("rst_stat", stat_cnt, 0);
`endif
        in_valid = 0; rst = 1;
        #1 check("rel_in_ready", in_ready, 1);

        // Single route to channel 2
        in_valid = 1; s = 2; d = 32'hDEADBEEF; out_ready = 0;
        step();
        in_valid = 0;
        check("route_out_valid", out_valid, 4'b0100);
        check("route_y2", y2, 32'hDEADBEEF);
        check("route_y0", y0, 0);
        check("route_y1", y1, 0);
        check("route_y3", y3, 0);
        out_ready = 4'b0100;
        step();
        out_ready = 0;
        check("drain2_out_valid", out_valid, 4'b0000);

        // Backpressure on channel 1
        in_valid = 1; s = 1; d = 32'h1;
        step();
        d = 32'h2;
        #1 check("bp_in_ready_lo", in_ready, 0);
        step();
        check("bp_y1_hold", y1, 32'h1);
        check("bp_out_valid", out_valid, 4'b0010);
        out_ready = 4'b0010;
        #1 check("bp_in_ready_hi", in_ready, 1);
        step();
        in_valid = 0; out_ready = 0;
        check("bp_y1_new", y1, 32'h2);
        check("bp_out_valid2", out_valid, 4'b0010);
`ifdef DEMUX4_STATS_EN
        check("bp_stat", stat_cnt, 32'h00010100);
`endif
        out_ready = 4'b0010;
        step();
        out_ready = 0;

        // Independence: stalled channel 0 does not block channel 3
        in_valid = 1; s = 0; d = 32'h12345678;
        step();
        s = 3; d = 32'hA5A5A5A5;
        #1 check("ind_in_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("ind_out_valid", out_valid, 4'b1001);
        check("ind_y0", y0, 32'h12345678);
        check("ind_y3", y3, 32'hA5A5A5A5);
`ifdef DEMUX4_STATS_EN
        check("ind_stat", stat_cnt, 32'h00010200);
`endif

        // Fill the rest, then every select sees in_ready low
        in_valid = 1; s = 1; d = 32'h33;
        step();
        s = 2; d = 32'h44;
        step();
        in_valid = 0;
        check("full_out_valid", out_valid, 4'b1111);
        check("full_y1", y1, 32'h33);
        check("full_y2", y2, 32'h44);
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #1 check("full_in_ready", in_ready, 0);
        end

        // Reset mid-operation discards everything
        rst = 0;
        step();
        rst = 1;
        check("mid_rst_out_valid", out_valid, 4'b0000);
        check("mid_rst_y1", y1, 0);
`ifdef DEMUX4_STATS_EN
        check("mid_rst_stat", stat_cnt, 0);

        // 256 handshakes on channel 0 wrap its counter
        out_ready = 4'b0001; in_valid = 1; s = 0; d = 0;
        step();
        for (int k = 1; k <= 255; k++) begin
            d = k;
            step();
        end
        check("wrap_255", stat_cnt, 32'h000000FF);
        in_valid = 0;
        step();
        out_ready = 0;
        check("wrap_0", stat_cnt, 32'h00000000);
        check("wrap_out_valid", out_valid, 4'b0000);
`endif

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
